// File: rtl/inst_fetch_pkg.sv
// ---------------------------------------------------------------------------
// inst_fetch_pkg
//   Shared constants and types for the instruction fetch front end.
//
//   WORD_ADDR_W      : width of a word (instruction) address
//   INST_W           : width of one instruction word
//   FIFO_DEPTH       : entries in the fetch buffer (fixed at 2)
//   CNT_W / PTR_W    : widths of the buffer occupancy count and pointers
//   RESET_PC_DEFAULT : default word address fetched first after reset
//   NOP_INST         : all-zero encoding, used as the cleared buffer contents
//   fetch_entry_t    : one buffered instruction with its word address
// ---------------------------------------------------------------------------
package inst_fetch_pkg;

    localparam int WORD_ADDR_W = 30;
    localparam int INST_W      = 32;

    localparam int FIFO_DEPTH  = 2;
    localparam int CNT_W       = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W       = $clog2(FIFO_DEPTH);

    localparam logic [WORD_ADDR_W-1:0] RESET_PC_DEFAULT = '0;
    localparam logic [INST_W-1:0]      NOP_INST         = 32'h0000_0000;

    typedef struct packed {
        logic [WORD_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } fetch_entry_t;

    localparam fetch_entry_t EMPTY_ENTRY = '{pc: '0, inst: NOP_INST};

    // Sequential word address; wraps from all-ones back to zero.
    function automatic logic [WORD_ADDR_W-1:0] pc_incr(input logic [WORD_ADDR_W-1:0] pc);
        return pc + WORD_ADDR_W'(1);
    endfunction

endpackage

// File: rtl/fetch_fifo2.sv
// ---------------------------------------------------------------------------
// fetch_fifo2
//   Two-entry FIFO of {pc, inst} pairs sitting between the ROM response and
//   decode. The head is read straight out of storage registers, so nothing
//   from the push side reaches the head combinationally.
//
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   push       : write push_entry at the tail this cycle
//   push_entry : {pc, inst} to write
//   pop        : consumer takes the head this cycle (ignored when empty)
//   flush      : drop all entries; wins over push and pop
//   head       : current head entry (meaningful when valid)
//   valid      : at least one entry held
//   count      : number of entries held
// ---------------------------------------------------------------------------
module fetch_fifo2
    import inst_fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    input  logic               flush,
    output fetch_entry_t       head,
    output logic               valid,
    output logic [CNT_W-1:0]   count
);

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             do_push;
    logic             do_pop;

    fetch_entry_t     entries [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_adv(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        do_push     = push && !flush;
        do_pop      = pop && (count_reg != '0) && !flush;

        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;

        if (flush) begin
            rd_ptr_next = '0;
            wr_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_next = ptr_adv(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_next = ptr_adv(rd_ptr_reg);
            end
            case ({do_push, do_pop})
                2'b10:   count_next = count_reg + CNT_W'(1);
                2'b01:   count_next = count_reg - CNT_W'(1);
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage: one register per slot. Slots are cleared only by reset; a
    // flush just rewinds the pointers, and stale contents are hidden by
    // valid going low.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
            fetch_entry_t entry_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    entry_reg <= EMPTY_ENTRY;
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= push_entry;
                end
            end

            assign entries[gi] = entry_reg;
        end
    endgenerate

    assign head  = entries[rd_ptr_reg];
    assign valid = (count_reg != '0);
    assign count = count_reg;

endmodule

// File: rtl/inst_fetch.sv
// ---------------------------------------------------------------------------
// inst_fetch
//   Instruction fetch front end. Drives a word address to a synchronous
//   instruction ROM, captures the returned word one cycle later into a
//   two-entry buffer, and presents the buffer head to decode with a
//   valid/ready handshake. Redirects flush the buffer, kill any response in
//   flight and restart fetch at the new target.
//
//   Parameters
//     RESET_PC        : word address fetched first after reset
//     BUF_DEPTH       : buffer depth; 2 is the only supported value
//
//   Ports
//     clk             : clock, all state on rising edge
//     rst             : asynchronous active-low reset
//     addr            : word address to the ROM (equals the fetch pc)
//     inst            : ROM data for the address sampled on the last edge
//     if_valid        : buffer head holds a valid instruction
//     if_ready        : decode accepts the head this cycle
//     if_inst         : head instruction
//     if_pc           : word address of the head instruction
//     redirect_valid  : redirect fetch this cycle
//     redirect_target : new word address
// ---------------------------------------------------------------------------
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter logic [WORD_ADDR_W-1:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int                     BUF_DEPTH = FIFO_DEPTH
)
(
    input  logic                   clk,
    input  logic                   rst,
    output logic [WORD_ADDR_W-1:0] addr,
    input  logic [INST_W-1:0]      inst,
    output logic                   if_valid,
    input  logic                   if_ready,
    output logic [INST_W-1:0]      if_inst,
    output logic [WORD_ADDR_W-1:0] if_pc,
    input  logic                   redirect_valid,
    input  logic [WORD_ADDR_W-1:0] redirect_target
);

    // Fetch pc and the single outstanding ROM request
    logic [WORD_ADDR_W-1:0] pc_reg, pc_next;
    logic                   inflight_reg, inflight_next;
    logic [WORD_ADDR_W-1:0] inflight_pc_reg, inflight_pc_next;

    // Buffer interface
    fetch_entry_t           fifo_head;
    fetch_entry_t           push_entry;
    logic                   fifo_valid;
    logic [CNT_W-1:0]       fifo_count;

    logic                   deq;
    logic                   issue;
    logic                   kill;
    logic                   resp_push;
    logic                   credit_ok;
    logic [CNT_W:0]         occupancy;

    always_comb begin
        deq        = fifo_valid && if_ready;

        // Credit: buffered entries plus the outstanding request must leave
        // room for the new response. A dequeue in the same cycle frees a
        // slot before that response lands, so it also grants a credit.
        occupancy  = {1'b0, fifo_count} + (CNT_W + 1)'(inflight_reg);
        credit_ok  = occupancy < (CNT_W + 1)'(BUF_DEPTH);
        issue      = !redirect_valid && (credit_ok || deq);

        // The ROM answers in the cycle after issue, so a redirect only has
        // to suppress the response arriving in the same cycle.
        kill       = redirect_valid && inflight_reg;
        resp_push  = inflight_reg && !kill;
        push_entry = '{pc: inflight_pc_reg, inst: inst};

        pc_next          = pc_reg;
        inflight_next    = issue;
        inflight_pc_next = inflight_pc_reg;

        if (redirect_valid) begin
            pc_next = redirect_target;
        end else if (issue) begin
            pc_next          = pc_incr(pc_reg);
            inflight_pc_next = pc_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_reg          <= RESET_PC;
            inflight_reg    <= 1'b0;
            inflight_pc_reg <= '0;
        end else begin
            pc_reg          <= pc_next;
            inflight_reg    <= inflight_next;
            inflight_pc_reg <= inflight_pc_next;
        end
    end

    fetch_fifo2 u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (resp_push),
        .push_entry (push_entry),
        .pop        (deq),
        .flush      (redirect_valid),
        .head       (fifo_head),
        .valid      (fifo_valid),
        .count      (fifo_count)
    );

    assign addr     = pc_reg;
    assign if_valid = fifo_valid;
    assign if_inst  = fifo_head.inst;
    assign if_pc    = fifo_head.pc;

endmodule

// File: tb/tb_inst_fetch.sv
module tb_inst_fetch;

    logic        clk;
    logic        rst;

    // Main DUT (RESET_PC = 0)
    logic [29:0] addr;
    logic [31:0] inst;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_inst;
    logic [29:0] if_pc;
    logic        redirect_valid;
    logic [29:0] redirect_target;

    // Second DUT exercising pc wrap (RESET_PC = 3FFFFFFE)
    logic [29:0] addr2;
    logic [31:0] inst2;
    logic        if_valid2;
    logic        if_ready2;
    logic [31:0] if_inst2;
    logic [29:0] if_pc2;
    logic        redirect_valid2;
    logic [29:0] redirect_target2;

    int n_cmp;
    int n_err;

    logic [29:0] rom_addr_reg;
    logic [29:0] rom_addr2_reg;

    inst_fetch dut (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr),
        .inst            (inst),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_inst         (if_inst),
        .if_pc           (if_pc),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target)
    );

    inst_fetch #(.RESET_PC(30'h3FFF_FFFE)) dut2 (
        .clk             (clk),
        .rst             (rst),
        .addr            (addr2),
        .inst            (inst2),
        .if_valid        (if_valid2),
        .if_ready        (if_ready2),
        .if_inst         (if_inst2),
        .if_pc           (if_pc2),
        .redirect_valid  (redirect_valid2),
        .redirect_target (redirect_target2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Test ROM contents: two fixed words, the rest derived from the address
    function automatic logic [31:0] rom_word(input logic [29:0] a);
        case (a)
            30'd0:   return 32'h3c0b1f00;
            30'd1:   return 32'h356b00c8;
            default: return {a, 2'b00} ^ 32'hA5A5_0F0F;
        endcase
    endfunction

    // Synchronous ROMs: address registered on posedge, data combinational after
    always @(posedge clk) begin
        rom_addr_reg  <= addr;
        rom_addr2_reg <= addr2;
    end
    assign inst  = rom_word(rom_addr_reg);
    assign inst2 = rom_word(rom_addr2_reg);

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("%0t FAIL %s: got %h, expected %h", $time, tag, got, exp);
        end else begin
            $display("%0t ok   %s = %h", $time, tag, got);
        end
    endtask

    task automatic expect_head(input string tag, input logic got_v, input logic [29:0] got_pc,
                               input logic [31:0] got_inst, input logic exp_v, input logic [29:0] exp_pc);
        check_eq({tag, "_valid"}, 32'(got_v), 32'(exp_v));
        if (exp_v) begin
            check_eq({tag, "_pc"}, 32'(got_pc), 32'(exp_pc));
            check_eq({tag, "_inst"}, got_inst, rom_word(exp_pc));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Buffer must never exceed two entries
    always @(negedge clk) begin
        if (rst && (dut.u_fifo.count_reg > 2'd2)) begin
            check_eq("fifo_overflow", 32'(dut.u_fifo.count_reg), 32'd2);
        end
    end

    initial begin
        n_cmp            = 0;
        n_err            = 0;
        rst              = 1'b0;
        if_ready         = 1'b1;
        redirect_valid   = 1'b0;
        redirect_target  = '0;
        if_ready2        = 1'b1;
        redirect_valid2  = 1'b0;
        redirect_target2 = '0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check_eq("rst_if_valid", 32'(if_valid), 32'd0);
        check_eq("rst_if_pc", 32'(if_pc), 32'd0);
        check_eq("rst_if_inst", if_inst, 32'd0);
        check_eq("rst_addr", 32'(addr), 32'd0);
        check_eq("rst_addr2", 32'(addr2), 32'h3FFF_FFFE);

        // ---------------- first fetch, streaming ----------------
        rst = 1'b1;                                         // cycle 0
        check_eq("c0_addr", 32'(addr), 32'd0);
        tick();                                             // cycle 1
        check_eq("c1_valid", 32'(if_valid), 32'd0);
        check_eq("c1_addr", 32'(addr), 32'd1);
        check_eq("c1_addr2", 32'(addr2), 32'h3FFF_FFFF);
        tick();                                             // cycle 2
        expect_head("c2", if_valid, if_pc, if_inst, 1'b1, 30'd0);
        check_eq("c2_inst_word0", if_inst, 32'h3c0b1f00);
        expect_head("wrap_c2", if_valid2, if_pc2, if_inst2, 1'b1, 30'h3FFF_FFFE);
        check_eq("c2_addr2_wrapped", 32'(addr2), 32'd0);
        tick();                                             // cycle 3
        expect_head("c3", if_valid, if_pc, if_inst, 1'b1, 30'd1);
        check_eq("c3_inst_word1", if_inst, 32'h356b00c8);
        expect_head("wrap_c3", if_valid2, if_pc2, if_inst2, 1'b1, 30'h3FFF_FFFF);
        tick();                                             // cycle 4
        expect_head("c4", if_valid, if_pc, if_inst, 1'b1, 30'd2);
        expect_head("wrap_c4", if_valid2, if_pc2, if_inst2, 1'b1, 30'd0);
        tick();                                             // cycle 5
        expect_head("c5", if_valid, if_pc, if_inst, 1'b1, 30'd3);

        // ---------------- backpressure ----------------
        rst      = 1'b0;
        tick();
        tick();
        if_ready = 1'b0;
        rst      = 1'b1;                                    // cycle 0
        tick();
        tick();                                             // cycle 2
        for (int i = 0; i < 5; i++) begin
            expect_head("stall", if_valid, if_pc, if_inst, 1'b1, 30'd0);
            check_eq("stall_two_issues", 32'(addr), 32'd2);
            tick();
        end
        expect_head("stall_end", if_valid, if_pc, if_inst, 1'b1, 30'd0);  // cycle 7
        if_ready = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            expect_head("release", if_valid, if_pc, if_inst, 1'b1, 30'(k));
        end
        check_eq("release_addr", 32'(addr), 32'd7);          // cycle 12

        // ---------------- redirect while full ----------------
        if_ready = 1'b0;
        tick();                                             // cycle 13: buffer full
        expect_head("full", if_valid, if_pc, if_inst, 1'b1, 30'd5);
        check_eq("full_no_issue", 32'(addr), 32'd7);
        redirect_valid  = 1'b1;
        redirect_target = 30'h25;
        if_ready        = 1'b1;                             // dequeue with redirect
        tick();                                             // n+1
        check_eq("redir_n1_valid", 32'(if_valid), 32'd0);
        check_eq("redir_n1_addr", 32'(addr), 32'h25);
        redirect_valid = 1'b0;
        tick();                                             // n+2
        check_eq("redir_n2_valid", 32'(if_valid), 32'd0);
        tick();                                             // n+3
        expect_head("redir_n3", if_valid, if_pc, if_inst, 1'b1, 30'h25);
        tick();
        expect_head("redir_n4", if_valid, if_pc, if_inst, 1'b1, 30'h26);

        // ---------------- back-to-back redirects ----------------
        redirect_valid  = 1'b1;
        redirect_target = 30'h10;
        tick();
        check_eq("b2b_first_valid", 32'(if_valid), 32'd0);
        check_eq("b2b_first_addr", 32'(addr), 32'h10);
        redirect_target = 30'h20;
        tick();
        check_eq("b2b_second_valid", 32'(if_valid), 32'd0);
        check_eq("b2b_second_addr", 32'(addr), 32'h20);
        redirect_valid = 1'b0;
        tick();
        check_eq("b2b_gap_valid", 32'(if_valid), 32'd0);
        tick();
        expect_head("b2b_first", if_valid, if_pc, if_inst, 1'b1, 30'h20);
        tick();
        expect_head("b2b_next", if_valid, if_pc, if_inst, 1'b1, 30'h21);

        // ---------------- redirect to current pc ----------------
        check_eq("self_addr", 32'(addr), 32'h23);
        redirect_valid  = 1'b1;
        redirect_target = 30'h23;
        tick();
        check_eq("self_n1_valid", 32'(if_valid), 32'd0);
        check_eq("self_n1_addr", 32'(addr), 32'h23);
        redirect_valid = 1'b0;
        tick();
        check_eq("self_n2_valid", 32'(if_valid), 32'd0);
        tick();
        expect_head("self_n3", if_valid, if_pc, if_inst, 1'b1, 30'h23);

        // ---------------- async reset with buffer full ----------------
        if_ready = 1'b0;
        tick();
        expect_head("pre_rst", if_valid, if_pc, if_inst, 1'b1, 30'h23);
        check_eq("pre_rst_addr", 32'(addr), 32'h25);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(if_valid), 32'd0);
        check_eq("async_rst_addr", 32'(addr), 32'd0);
        check_eq("async_rst_pc", 32'(if_pc), 32'd0);
        check_eq("async_rst_inst", if_inst, 32'd0);
        @(negedge clk);
        @(negedge clk);
        if_ready = 1'b1;
        rst      = 1'b1;                                    // cycle 0
        tick();
        check_eq("restart_c1_valid", 32'(if_valid), 32'd0);
        tick();
        expect_head("restart_c2", if_valid, if_pc, if_inst, 1'b1, 30'd0);
        tick();
        expect_head("restart_c3", if_valid, if_pc, if_inst, 1'b1, 30'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
